// File: rtl/fetch_unit.sv
// Nibble-serial instruction fetch: walks an 8-phase machine cycle, assembles one- and
// two-word instructions from ROM nibbles and presents them with a one-clock valid pulse.
module fetch_unit #(
   parameter logic [11:0] RESET_PC = 12'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   output logic [11:0] romAddr,
   output logic [2:0]  cycle,
   input  logic [3:0]  romNibble,
   input  logic        jumpValid,
   input  logic [11:0] jumpAddr,
   output logic        instrValid,
   output logic [7:0]  instrByte1,
   output logic [7:0]  instrByte2,
   output logic        twoWord,
   output logic [11:0] instrPc
);

   typedef enum logic {FETCH1, FETCH2} state_t;

   state_t      state_q;
   logic [2:0]  cycle_q;
   logic [11:0] pc_q;
   logic [3:0]  hiNibble_q;
   logic [7:0]  pendByte1_q;
   logic [11:0] pendPc_q;
   logic        pendTwo_q;
   logic        issued_q;
   logic        instrValid_q;
   logic [7:0]  instrByte1_q;
   logic [7:0]  instrByte2_q;
   logic        twoWord_q;
   logic [11:0] instrPc_q;

   logic [7:0]  curByte_d;
   logic        isTwoWord_d;
   logic [11:0] pcNext_d;

   always_comb begin
      curByte_d   = {hiNibble_q, romNibble};
      isTwoWord_d = (curByte_d[7:4] == 4'h1) || (curByte_d[7:4] == 4'h4) ||
                    (curByte_d[7:4] == 4'h5) || (curByte_d[7:4] == 4'h7) ||
                    ((curByte_d[7:4] == 4'h2) && !curByte_d[0]);
      // A jump is honoured only in the machine cycle that actually delivered an instruction
      pcNext_d    = (jumpValid && issued_q) ? jumpAddr : pc_q + 12'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FETCH1;
         cycle_q      <= 3'd0;
         pc_q         <= RESET_PC;
         hiNibble_q   <= 4'h0;
         pendByte1_q  <= 8'h00;
         pendPc_q     <= RESET_PC;
         pendTwo_q    <= 1'b0;
         issued_q     <= 1'b0;
         instrValid_q <= 1'b0;
         instrByte1_q <= 8'h00;
         instrByte2_q <= 8'h00;
         twoWord_q    <= 1'b0;
         instrPc_q    <= RESET_PC;
      end else if (run) begin
         cycle_q      <= cycle_q + 3'd1;
         instrValid_q <= 1'b0;
         case (cycle_q)
            3'd3: hiNibble_q <= romNibble;
            3'd4: begin
               if (state_q == FETCH2) begin
                  instrValid_q <= 1'b1;
                  issued_q     <= 1'b1;
                  instrByte1_q <= pendByte1_q;
                  instrByte2_q <= curByte_d;
                  twoWord_q    <= 1'b1;
                  instrPc_q    <= pendPc_q;
               end else if (isTwoWord_d) begin
                  // First word held privately so the visible outputs stay stable until issue
                  pendByte1_q <= curByte_d;
                  pendPc_q    <= pc_q;
                  pendTwo_q   <= 1'b1;
               end else begin
                  instrValid_q <= 1'b1;
                  issued_q     <= 1'b1;
                  instrByte1_q <= curByte_d;
                  instrByte2_q <= 8'h00;
                  twoWord_q    <= 1'b0;
                  instrPc_q    <= pc_q;
               end
            end
            3'd7: begin
               pc_q      <= pcNext_d;
               issued_q  <= 1'b0;
               pendTwo_q <= 1'b0;
               state_q   <= (state_q == FETCH1 && pendTwo_q) ? FETCH2 : FETCH1;
            end
            default: ;
         endcase
      end
   end

   assign romAddr    = pc_q;
   assign cycle      = cycle_q;
   assign instrValid = instrValid_q;
   assign instrByte1 = instrByte1_q;
   assign instrByte2 = instrByte2_q;
   assign twoWord    = twoWord_q;
   assign instrPc    = instrPc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural ROM feeds the DUT, expected instructions
// are queued as ROM contents are set up and popped when instrValid first rises.
module tb_fetch_unit;

   typedef struct {
      logic [7:0]  byte1;
      logic [7:0]  byte2;
      logic        two;
      logic [11:0] pc;
   } exp_t;

   typedef struct {
      logic [7:0] op;
      logic [7:0] arg;
      logic       expTwo;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b1;
   logic [11:0] romAddr;
   logic [2:0]  cycle;
   logic [3:0]  romNibble;
   logic        jumpValid = 1'b0;
   logic [11:0] jumpAddr = 12'h000;
   logic        instrValid;
   logic [7:0]  instrByte1;
   logic [7:0]  instrByte2;
   logic        twoWord;
   logic [11:0] instrPc;

   logic        rst2 = 1'b1;
   logic        jumpValid2 = 1'b0;
   logic [11:0] jumpAddr2 = 12'h000;
   logic [11:0] romAddr2;
   logic [2:0]  cycle2;
   logic [3:0]  romNibble2;
   logic        instrValid2;
   logic [7:0]  instrByte1b;
   logic [7:0]  instrByte2b;
   logic        twoWord2;
   logic [11:0] instrPc2;

   logic [7:0]  rom  [4096];
   logic [7:0]  rom2 [4096];
   exp_t        expQ [$];
   vec_t        vecs [10];
   int          checkCount = 0;
   int          errorCount = 0;
   logic        seen = 1'b0;

   fetch_unit #(.RESET_PC(12'h000)) dut (
      .clk(clk), .rst(rst), .run(run), .romAddr(romAddr), .cycle(cycle),
      .romNibble(romNibble), .jumpValid(jumpValid), .jumpAddr(jumpAddr),
      .instrValid(instrValid), .instrByte1(instrByte1), .instrByte2(instrByte2),
      .twoWord(twoWord), .instrPc(instrPc)
   );

   fetch_unit #(.RESET_PC(12'hFFF)) dut2 (
      .clk(clk), .rst(rst2), .run(run), .romAddr(romAddr2), .cycle(cycle2),
      .romNibble(romNibble2), .jumpValid(jumpValid2), .jumpAddr(jumpAddr2),
      .instrValid(instrValid2), .instrByte1(instrByte1b), .instrByte2(instrByte2b),
      .twoWord(twoWord2), .instrPc(instrPc2)
   );

   always #5 clk = ~clk;

   assign romNibble  = (cycle == 3'd3)  ? rom[romAddr][7:4]   : rom[romAddr][3:0];
   assign romNibble2 = (cycle2 == 3'd3) ? rom2[romAddr2][7:4] : rom2[romAddr2][3:0];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Compare each new instruction once, even if run=0 stretches the valid pulse
   always @(negedge clk) begin
      if (rst) begin
         seen = 1'b0;
      end else if (instrValid) begin
         if (!seen) begin
            seen = 1'b1;
            if (expQ.size() == 0) begin
               checkOutput("unexpectedValid", 32'(instrByte1), 32'hFFFF);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput("validPhase", 32'(cycle), 32'd5);
               checkOutput("instrByte1", 32'(instrByte1), 32'(e.byte1));
               checkOutput("instrByte2", 32'(instrByte2), 32'(e.byte2));
               checkOutput("twoWord", 32'(twoWord), 32'(e.two));
               checkOutput("instrPc", 32'(instrPc), 32'(e.pc));
            end
         end
      end else begin
         seen = 1'b0;
      end
   end

   task automatic pushExp(input logic [7:0] b1, input logic [7:0] b2, input logic two,
                          input logic [11:0] pc);
      exp_t e;
      e.byte1 = b1; e.byte2 = b2; e.two = two; e.pc = pc;
      expQ.push_back(e);
   endtask

   // Hold reset, clear ROM, optionally place two bytes at 000/001, release on a falling edge
   task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1);
      rst = 1'b1;
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
      rom[0] = b0;
      rom[1] = b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while (expQ.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("drainPending", 32'(expQ.size()), 32'd0);
      expQ.delete();
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 4096; i++) rom2[i] = 8'h00;
      rom2[12'hFFF] = 8'h50;
      rom2[12'h000] = 8'h12;
      rom2[12'h001] = 8'h85;

      vecs[0] = '{8'h20, 8'hAB, 1'b1};
      vecs[1] = '{8'h21, 8'hAB, 1'b0};
      vecs[2] = '{8'h10, 8'h33, 1'b1};
      vecs[3] = '{8'h40, 8'h23, 1'b1};
      vecs[4] = '{8'h5E, 8'h12, 1'b1};
      vecs[5] = '{8'h7C, 8'h44, 1'b1};
      vecs[6] = '{8'h85, 8'h11, 1'b0};
      vecs[7] = '{8'hF2, 8'h66, 1'b0};
      vecs[8] = '{8'h30, 8'h55, 1'b0};
      vecs[9] = '{8'h2E, 8'h77, 1'b1};

      // Reset values while reset is held
      @(negedge clk);
      checkOutput("rstValid", 32'(instrValid), 32'd0);
      checkOutput("rstByte1", 32'(instrByte1), 32'h00);
      checkOutput("rstByte2", 32'(instrByte2), 32'h00);
      checkOutput("rstTwoWord", 32'(twoWord), 32'd0);
      checkOutput("rstInstrPc", 32'(instrPc), 32'h000);
      checkOutput("rstRomAddr", 32'(romAddr), 32'h000);
      checkOutput("rstCycle", 32'(cycle), 32'd0);

      // Three sequential one-word instructions
      applyStimulus(8'h00, 8'h85);
      rom[2] = 8'h97;
      pushExp(8'h00, 8'h00, 1'b0, 12'h000);
      pushExp(8'h85, 8'h00, 1'b0, 12'h001);
      pushExp(8'h97, 8'h00, 1'b0, 12'h002);
      waitDrain(40);

      // Classification table
      for (int v = 0; v < 10; v++) begin
         applyStimulus(vecs[v].op, vecs[v].arg);
         pushExp(vecs[v].op, vecs[v].expTwo ? vecs[v].arg : 8'h00, vecs[v].expTwo, 12'h000);
         waitDrain(30);
      end

      // JUN with jumpValid held high: only the FETCH2 cycle-7 request may redirect
      applyStimulus(8'h40, 8'h23);
      rom[12'h023] = 8'h85;
      jumpValid = 1'b1;
      jumpAddr  = 12'h023;
      pushExp(8'h40, 8'h23, 1'b1, 12'h000);
      pushExp(8'h85, 8'h00, 1'b0, 12'h023);
      waitDrain(40);
      checkOutput("jumpRomAddr", 32'(romAddr), 32'h023);
      jumpValid = 1'b0;

      // Reset during FETCH2 cycle 3 aborts the pending two-word instruction
      applyStimulus(8'h85, 8'h40);
      rom[2] = 8'h23;
      pushExp(8'h85, 8'h00, 1'b0, 12'h000);
      waitDrain(30);
      repeat (14) @(negedge clk);
      checkOutput("preAbortCycle", 32'(cycle), 32'd3);
      #2 rst = 1'b1;
      #1;
      checkOutput("abortByte1", 32'(instrByte1), 32'h00);
      checkOutput("abortInstrPc", 32'(instrPc), 32'h000);
      checkOutput("abortRomAddr", 32'(romAddr), 32'h000);
      checkOutput("abortCycle", 32'(cycle), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pushExp(8'h85, 8'h00, 1'b0, 12'h000);
      waitDrain(30);

      // Freeze at cycle 4, then freeze during the valid pulse
      applyStimulus(8'h97, 8'h00);
      repeat (4) @(negedge clk);
      run = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("frozenCycle", 32'(cycle), 32'd4);
      checkOutput("frozenRomAddr", 32'(romAddr), 32'h000);
      checkOutput("frozenValid", 32'(instrValid), 32'd0);
      run = 1'b1;
      pushExp(8'h97, 8'h00, 1'b0, 12'h000);
      waitDrain(20);
      run = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("heldValid", 32'(instrValid), 32'd1);
      checkOutput("heldCycle", 32'(cycle), 32'd5);
      run = 1'b1;
      @(negedge clk);
      checkOutput("releasedValid", 32'(instrValid), 32'd0);
      checkOutput("releasedCycle", 32'(cycle), 32'd6);

      // RESET_PC = FFF: second word wraps to 000, next PC is 001
      rst = 1'b1;
      @(negedge clk);
      rst2 = 1'b0;
      begin
         int n = 0;
         while (!instrValid2 && n < 40) begin
            @(negedge clk);
            n++;
         end
      end
      checkOutput("wrapValid", 32'(instrValid2), 32'd1);
      checkOutput("wrapByte1", 32'(instrByte1b), 32'h50);
      checkOutput("wrapByte2", 32'(instrByte2b), 32'h12);
      checkOutput("wrapTwoWord", 32'(twoWord2), 32'd1);
      checkOutput("wrapInstrPc", 32'(instrPc2), 32'hFFF);
      repeat (3) @(negedge clk);
      checkOutput("wrapNextPc", 32'(romAddr2), 32'h001);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
